// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus responder: register offsets,
// status bit positions and the key-interrupt state encoding.
package mmio_pkg;

  localparam logic [63:0] KEY_DATA = 64'd0;
  localparam logic [63:0] KEY_STAT = 64'd8;
  localparam logic [63:0] KEY_CTRL = 64'd16;

  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_ART_VALID = 1;
  localparam int STAT_OVERFLOW  = 2;

  localparam logic [3:0] IRQ_VEC_NONE = 4'd0;
  localparam logic [3:0] IRQ_VEC_KEY  = 4'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/mmio_bus_responder_key_fifo.sv
// Synchronous key-byte FIFO. A push while full is accepted only when a pop
// happens in the same cycle, so the occupancy then stays at DEPTH.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; clearing the pointers is enough to discard it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_bus_responder.sv
// MMIO target for the core load/store port: key FIFO reads, ART transmit
// register writes, key IRQ sequencing. Optional MMIO_IRQ_MASK_EN adds ctrl reg.
module mmio_bus_responder
  import mmio_pkg::*;
#(
  parameter logic [63:0] KEY_BASE   = 64'h0000_0000_1000_0000,
  parameter logic [63:0] ART_BASE   = 64'h0000_0000_1000_0100,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic [3:0]  interrupt_vector,
  input  logic        interrupt_ack,
  input  logic        interrupt_pending,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic        art_valid,
  output logic [7:0]  art_data,
  input  logic        art_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit_kdata, hit_kstat, hit_kctrl, hit_art;
  logic          rd_kdata, rd_kstat;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          key_drop, art_wr, art_take, art_drop, art_hs;
  logic          overflow, irq_en;
  logic [63:0]   rd_mux;
  irq_state_e    state, state_nx;

  assign hit_kdata = (bus_address == KEY_BASE + KEY_DATA);
  assign hit_kstat = (bus_address == KEY_BASE + KEY_STAT);
  assign hit_kctrl = (bus_address == KEY_BASE + KEY_CTRL);
  assign hit_art   = (bus_address == ART_BASE);

  assign rd_kdata = bus_read_enable & hit_kdata;
  assign rd_kstat = bus_read_enable & hit_kstat;

  key_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_key_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (key_valid),
    .pop   (rd_kdata),
    .wdata (key_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A full FIFO is never empty, so a data read always frees a slot.
  assign key_drop = key_valid & fifo_full & ~rd_kdata;

  assign art_hs   = art_valid & art_ready;
  assign art_wr   = bus_write_enable & hit_art;
  assign art_take = art_wr & (~art_valid | art_ready);
  assign art_drop = art_wr & art_valid & ~art_ready;

`ifdef MMIO_IRQ_MASK_EN
  always_ff @(posedge clk) begin
    if (!reset)                          irq_en <= 1'b1;
    else if (bus_write_enable & hit_kctrl) irq_en <= bus_write_data[0];
  end
`else
  assign irq_en = 1'b1;
`endif

  always_comb begin
    rd_mux = '0;
    if (hit_kdata && !fifo_empty) begin
      rd_mux = {56'b0, fifo_head};
    end else if (hit_kstat) begin
      rd_mux[STAT_NONEMPTY]  = ~fifo_empty;
      rd_mux[STAT_ART_VALID] = art_valid;
      rd_mux[STAT_OVERFLOW]  = overflow;
    end
`ifdef MMIO_IRQ_MASK_EN
    else if (hit_kctrl) begin
      rd_mux[0] = irq_en;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset)               bus_read_data <= '0;
    else if (bus_read_enable) bus_read_data <= rd_mux;
  end

  // A new drop in the same cycle as a status read keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset)                    overflow <= 1'b0;
    else if (key_drop | art_drop)  overflow <= 1'b1;
    else if (rd_kstat)             overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      art_valid <= 1'b0;
      art_data  <= '0;
    end else if (art_take) begin
      art_valid <= 1'b1;
      art_data  <= bus_write_data[7:0];
    end else if (art_hs) begin
      art_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      interrupt_vector <= IRQ_VEC_NONE;
    end else begin
      state            <= state_nx;
      interrupt_vector <= (state_nx == REQ) ? IRQ_VEC_KEY : IRQ_VEC_NONE;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!fifo_empty && irq_en && !interrupt_pending) state_nx = REQ;
      REQ:     if (interrupt_ack)                state_nx = SERVICE;
               else if (fifo_empty || !irq_en)   state_nx = IDLE;
      SERVICE: if (!interrupt_pending)           state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{bus_write_data[63:8], fifo_count, hit_kctrl};

endmodule
